// File: rtl/min_node_scan.sv
// Scans 16 distance entries (four groups of four) and reports the lowest-index
// minimum among the unvisited nodes.
module min_node_scan #(
    parameter int              DIST_W = 11,
    parameter logic [DIST_W-1:0] INF  = 11'h7FF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [15:0]         visited,
    output logic                rd_en,
    output logic [1:0]          rd_addr,
    input  logic [4*DIST_W-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic [3:0]          min_idx,
    output logic [DIST_W-1:0]   min_dist,
    output logic                found,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Handshake: rd_en/rd_addr request a group; memory returns it on rd_data the
    // next cycle, tracked by pend_vld/pend_grp so stale data is never consumed.
    logic [1:0]        state, state_nxt;
    logic [1:0]        grp;
    logic [15:0]       vis_q;
    logic              pend_vld;
    logic [1:0]        pend_grp;
    logic [DIST_W-1:0] acc_dist;
    logic [3:0]        acc_idx;

    logic [DIST_W-1:0] d [4];
    logic              sel01, sel23, sel_w;
    logic [DIST_W-1:0] min01, min23, gmin;
    logic [1:0]        gj;
    logic              take;
    logic [DIST_W-1:0] nxt_dist;
    logic [3:0]        nxt_idx;

    assign rd_en     = (state == S_ISSUE);
    assign rd_addr   = grp;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            d[j] = rd_data[j*DIST_W +: DIST_W];
            if (vis_q[{pend_grp, 2'(j)}]) d[j] = INF;
        end
    end

    // Strict less-than everywhere so equal distances keep the lower index.
    always_comb begin
        sel01    = (d[1] < d[0]);
        min01    = sel01 ? d[1] : d[0];
        sel23    = (d[3] < d[2]);
        min23    = sel23 ? d[3] : d[2];
        sel_w    = (min23 < min01);
        gmin     = sel_w ? min23 : min01;
        gj       = sel_w ? {1'b1, sel23} : {1'b0, sel01};
        take     = pend_vld && (gmin < acc_dist);
        nxt_dist = take ? gmin : acc_dist;
        nxt_idx  = take ? {pend_grp, gj} : acc_idx;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: if (abort) state_nxt = S_IDLE;
                     else if (grp == 2'd3) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = abort ? S_IDLE : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            grp      <= 2'd0;
            vis_q    <= 16'd0;
            pend_vld <= 1'b0;
            pend_grp <= 2'd0;
            acc_dist <= INF;
            acc_idx  <= 4'd0;
            min_idx  <= 4'd0;
            min_dist <= INF;
            found    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_vld <= rd_en && !abort;
            pend_grp <= grp;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        vis_q    <= visited;
                        acc_dist <= INF;
                        acc_idx  <= 4'd0;
                        grp      <= 2'd0;
                    end
                end
                S_ISSUE: begin
                    grp      <= abort ? 2'd0 : grp + 2'd1;
                    acc_dist <= nxt_dist;
                    acc_idx  <= nxt_idx;
                end
                S_DRAIN: begin
                    acc_dist <= nxt_dist;
                    acc_idx  <= nxt_idx;
                    // Results land together with the done cycle.
                    if (!abort) begin
                        min_dist <= nxt_dist;
                        min_idx  <= nxt_idx;
                        found    <= (nxt_dist != INF);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_min_node_scan.sv
// Directed bench for min_node_scan: timing, tie rules, masking, abort and reset.
module tb_min_node_scan;

    localparam int DW = 11;
    localparam logic [DW-1:0] INF_V = 11'h7FF;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [15:0]     visited = 16'd0;
    logic            rd_en;
    logic [1:0]      rd_addr;
    logic [4*DW-1:0] rd_data = '0;
    logic            busy;
    logic            done;
    logic [3:0]      min_idx;
    logic [DW-1:0]   min_dist;
    logic            found;
    logic [1:0]      dbg_state;

    logic [DW-1:0]   mem [16];
    int              errors = 0;
    int              checks = 0;

    min_node_scan #(.DIST_W(DW), .INF(INF_V)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .visited(visited), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .min_idx(min_idx), .min_dist(min_dist),
        .found(found), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Distance memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (rd_en)
            rd_data <= {mem[{rd_addr, 2'd3}], mem[{rd_addr, 2'd2}],
                        mem[{rd_addr, 2'd1}], mem[{rd_addr, 2'd0}]};
        else
            rd_data <= 44'({$urandom(), $urandom()});
    end

    task automatic fill_base(input int base, input int step);
        for (int i = 0; i < 16; i++) mem[i] = DW'(base + step * i);
    endtask

    task automatic do_scan(output int lat, output logic [7:0] trace,
                           output int n_rd, output int n_done);
        lat = -1; trace = 8'd0; n_rd = 0; n_done = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rd_en) begin
                trace = {trace[5:0], rd_addr};
                n_rd++;
            end
            if (done) begin
                n_done++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
        checks++; if (rd_addr !== 2'd0) begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        checks++; if (min_idx !== 4'd0) begin errors++; $display("FAIL reset_min_idx got=%0d exp=0", min_idx); end
        checks++; if (min_dist !== INF_V) begin errors++; $display("FAIL reset_min_dist got=%h exp=7ff", min_dist); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset_found got=%b exp=0", found); end
        reset_n = 1'b1;
    endtask

    task automatic test_sequential;
        int lat, n_rd, n_done;
        logic [7:0] trace;
        fill_base(100, 1);
        visited = 16'h0000;
        do_scan(lat, trace, n_rd, n_done);
        checks++; if (lat != 6) begin errors++; $display("FAIL seq_latency got=%0d exp=6", lat); end
        checks++; if (trace !== 8'h1B) begin errors++; $display("FAIL seq_addr_trace got=%h exp=1b", trace); end
        checks++; if (n_rd != 4) begin errors++; $display("FAIL seq_rd_count got=%0d exp=4", n_rd); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL seq_done_count got=%0d exp=1", n_done); end
        checks++; if (min_idx !== 4'd0) begin errors++; $display("FAIL seq_min_idx got=%0d exp=0", min_idx); end
        checks++; if (min_dist !== 11'd100) begin errors++; $display("FAIL seq_min_dist got=%0d exp=100", min_dist); end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL seq_found got=%b exp=1", found); end
    endtask

    task automatic test_tie;
        int lat, n_rd, n_done;
        logic [7:0] trace;
        fill_base(300, 0);
        mem[13] = 11'd5; mem[6] = 11'd5;
        visited = 16'h0000;
        do_scan(lat, trace, n_rd, n_done);
        checks++; if (min_idx !== 4'd6) begin errors++; $display("FAIL tie_cross_idx got=%0d exp=6", min_idx); end
        checks++; if (min_dist !== 11'd5) begin errors++; $display("FAIL tie_cross_dist got=%0d exp=5", min_dist); end
        visited = 16'h0040;
        do_scan(lat, trace, n_rd, n_done);
        checks++; if (min_idx !== 4'd13) begin errors++; $display("FAIL tie_masked_idx got=%0d exp=13", min_idx); end
        checks++; if (min_dist !== 11'd5) begin errors++; $display("FAIL tie_masked_dist got=%0d exp=5", min_dist); end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL tie_masked_found got=%b exp=1", found); end
        fill_base(300, 0);
        mem[2] = 11'd2; mem[3] = 11'd2; mem[9] = 11'd2;
        visited = 16'h0000;
        do_scan(lat, trace, n_rd, n_done);
        checks++; if (min_idx !== 4'd2) begin errors++; $display("FAIL tie_pair_idx got=%0d exp=2", min_idx); end
        checks++; if (min_dist !== 11'd2) begin errors++; $display("FAIL tie_pair_dist got=%0d exp=2", min_dist); end
    endtask

    task automatic test_abort;
        int lat, n_done;
        fill_base(500, -1);
        visited = 16'h0000;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL abort_rd_en got=%b exp=0", rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (min_idx !== 4'd2 || min_dist !== 11'd2) begin
            errors++; $display("FAIL abort_hold got=%0d/%0d exp=2/2", min_idx, min_dist);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1; n_done = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (lat < 0) lat = k;
            end
        end
        checks++; if (lat != 6) begin errors++; $display("FAIL abort_restart_latency got=%0d exp=6", lat); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL abort_restart_done_count got=%0d exp=1", n_done); end
        checks++; if (min_idx !== 4'd15) begin errors++; $display("FAIL abort_restart_idx got=%0d exp=15", min_idx); end
        checks++; if (min_dist !== 11'd485) begin errors++; $display("FAIL abort_restart_dist got=%0d exp=485", min_dist); end
    endtask

    task automatic test_reset_mid_scan;
        int lat, n_done;
        fill_base(40, 3);
        visited = 16'h0000;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl got=busy%b rd%b done%b exp=000", busy, rd_en, done);
        end
        checks++; if (min_dist !== INF_V || min_idx !== 4'd0 || found !== 1'b0) begin
            errors++; $display("FAIL rst_mid_results got=%h/%0d/%b exp=7ff/0/0", min_dist, min_idx, found);
        end
        @(negedge clk); reset_n = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1; n_done = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (lat < 0) lat = k;
            end
        end
        checks++; if (lat != 6) begin errors++; $display("FAIL rst_first_start_latency got=%0d exp=6", lat); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL rst_done_count got=%0d exp=1", n_done); end
        checks++; if (min_idx !== 4'd0 || min_dist !== 11'd40) begin
            errors++; $display("FAIL rst_rescan_result got=%0d/%0d exp=0/40", min_idx, min_dist);
        end
    endtask

    task automatic test_start_during_busy;
        int n_done;
        logic busy_k7;
        fill_base(100, 1);
        visited = 16'h0001;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_done = 0; busy_k7 = 1'bx;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (k == 7) busy_k7 = busy;
            start = (k == 2 || k == 3 || k == 6);
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL busy_start_done_count got=%0d exp=1", n_done); end
        checks++; if (busy_k7 !== 1'b0) begin errors++; $display("FAIL start_in_done_ignored busy=%b exp=0", busy_k7); end
        checks++; if (min_idx !== 4'd1 || min_dist !== 11'd101) begin
            errors++; $display("FAIL busy_start_result got=%0d/%0d exp=1/101", min_idx, min_dist);
        end
    endtask

    task automatic test_all_inf;
        int lat, n_rd, n_done;
        logic [7:0] trace;
        fill_base(2047, 0);
        visited = 16'h0000;
        do_scan(lat, trace, n_rd, n_done);
        checks++; if (found !== 1'b0 || min_dist !== INF_V || min_idx !== 4'd0) begin
            errors++; $display("FAIL all_inf got=%b/%h/%0d exp=0/7ff/0", found, min_dist, min_idx);
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL all_inf_done got=%0d exp=1", n_done); end
        fill_base(20, 7);
        visited = 16'hFFFF;
        do_scan(lat, trace, n_rd, n_done);
        checks++; if (found !== 1'b0 || min_dist !== INF_V || min_idx !== 4'd0) begin
            errors++; $display("FAIL all_visited got=%b/%h/%0d exp=0/7ff/0", found, min_dist, min_idx);
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_sequential();
        test_tie();
        test_abort();
        test_reset_mid_scan();
        test_start_during_busy();
        test_all_inf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
